// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl
//   Round/score controller for the number-conversion quiz. Each round asks
//   the RNG for a target, runs a countdown on the LED bar that gets faster as
//   the level rises, and judges debounced submits against the latched target.
//   It also tracks score and lives, and handles game-over and restart.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   submit         debounced single-cycle submit pulse
//   guess          player answer (switches)
//   target         RNG value, qualified by target_valid
//   new_req        one-cycle pulse asking the RNG for a new target
//   leds           thermometer of remaining round time
//   level, score   current level / correct answers this game
//   lives_left     remaining lives
//   game_over      high while the game is over
//   hit, miss      one-cycle pulses for correct / wrong-or-timeout
module quiz_round_ctrl #(
  parameter  int WIDTH         = 10,
  parameter  int NUM_LEVELS    = 8,
  parameter  int LED_COUNT     = 16,
  parameter  int TICKS_PER_LED = 50_000_000,
  parameter  int LIVES         = 3,
  localparam int LVL_W         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIV_W         = $clog2(LIVES + 1),
  localparam int CNT_W         = (TICKS_PER_LED > 1) ? $clog2(TICKS_PER_LED) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 submit,
  input  logic [WIDTH-1:0]     guess,
  input  logic [WIDTH-1:0]     target,
  input  logic                 target_valid,
  output logic                 new_req,
  output logic [LED_COUNT-1:0] leds,
  output logic [LVL_W-1:0]     level,
  output logic [15:0]          score,
  output logic [LIV_W-1:0]     lives_left,
  output logic                 game_over,
  output logic                 hit,
  output logic                 miss
);

  typedef enum logic [1:0] {S_LOAD, S_PLAY, S_OVER} state_t;

  state_t                 state, state_d;
  logic                   req_pend, req_pend_d;  // new_req still owed for this S_LOAD visit
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [WIDTH-1:0]       tgt, tgt_d;
  logic [LED_COUNT-1:0]   leds_d;
  logic [LVL_W-1:0]       level_d;
  logic [15:0]            score_d;
  logic [LIV_W-1:0]       lives_d;
  logic                   go_d, hit_d, miss_d, new_req_d;

  // Segment period halves per level, never below one cycle.
  logic [31:0] shifted, period;
  logic        tick_end, timeout, correct;

  always_comb begin
    shifted  = 32'(TICKS_PER_LED) >> level;
    period   = (shifted == 32'd0) ? 32'd1 : shifted;
    tick_end = ({{(32-CNT_W){1'b0}}, cnt} == period - 32'd1);
    timeout  = tick_end && (leds == LED_COUNT'(1));
    correct  = submit && (guess == tgt);
  end

  always_comb begin
    state_d    = state;
    req_pend_d = req_pend;
    cnt_d      = cnt;
    tgt_d      = tgt;
    leds_d     = leds;
    level_d    = level;
    score_d    = score;
    lives_d    = lives_left;
    go_d       = game_over;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    new_req_d  = 1'b0;
    case (state)
      S_LOAD: begin
        if (req_pend) begin
          new_req_d  = 1'b1;
          req_pend_d = 1'b0;
        end else if (!new_req && target_valid) begin
          // Values arriving during the request cycle itself are stale.
          tgt_d   = target;
          leds_d  = '1;
          cnt_d   = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_end) begin
          cnt_d  = '0;
          leds_d = leds >> 1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
        if (correct) begin
          // A correct answer beats a coincident timeout.
          hit_d      = 1'b1;
          score_d    = (score == 16'hFFFF) ? score : score + 16'd1;
          level_d    = (level == LVL_W'(NUM_LEVELS - 1)) ? level : level + LVL_W'(1);
          leds_d     = '0;
          state_d    = S_LOAD;
          req_pend_d = 1'b1;
        end else if (submit || timeout) begin
          // Wrong submit and timeout together still cost a single life.
          miss_d  = 1'b1;
          lives_d = lives_left - LIV_W'(1);
          if (lives_left == LIV_W'(1)) begin
            state_d = S_OVER;
            go_d    = 1'b1;
            leds_d  = '0;
          end else if (timeout) begin
            state_d    = S_LOAD;
            req_pend_d = 1'b1;
            leds_d     = '0;
          end
        end
      end
      S_OVER: begin
        leds_d = '0;
        go_d   = 1'b1;
        if (submit) begin
          score_d    = '0;
          level_d    = '0;
          lives_d    = LIV_W'(LIVES);
          go_d       = 1'b0;
          state_d    = S_LOAD;
          req_pend_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_LOAD;
        req_pend_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      req_pend   <= 1'b1;
      cnt        <= '0;
      tgt        <= '0;
      leds       <= '0;
      level      <= '0;
      score      <= '0;
      lives_left <= LIV_W'(LIVES);
      game_over  <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      new_req    <= 1'b0;
    end else begin
      state      <= state_d;
      req_pend   <= req_pend_d;
      cnt        <= cnt_d;
      tgt        <= tgt_d;
      leds       <= leds_d;
      level      <= level_d;
      score      <= score_d;
      lives_left <= lives_d;
      game_over  <= go_d;
      hit        <= hit_d;
      miss       <= miss_d;
      new_req    <= new_req_d;
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: a table of cycle vectors for the basic flow,
// then hand-written sequences for countdown timing, level saturation,
// coincident submit/timeout and mid-round reset.
module tb_quiz_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, submit, target_valid;
  logic [9:0] guess, target;
  logic       new_req, game_over, hit, miss;
  logic [3:0] leds;
  logic [1:0] level, lives_left;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quiz_round_ctrl #(
    .WIDTH(10), .NUM_LEVELS(4), .LED_COUNT(4), .TICKS_PER_LED(8), .LIVES(2)
  ) dut (
    .clk(clk), .reset(reset), .submit(submit), .guess(guess),
    .target(target), .target_valid(target_valid), .new_req(new_req),
    .leds(leds), .level(level), .score(score), .lives_left(lives_left),
    .game_over(game_over), .hit(hit), .miss(miss)
  );

  typedef struct {
    logic       rst, sub;
    logic [9:0] gs, tg;
    logic       tv;
    logic       nr;
    logic [3:0] lds;
    logic       chk_lds;
    logic [1:0] lvl;
    logic [15:0] sc;
    logic [1:0] lv;
    logic       go, h, m;
  } vec_t;

  function automatic vec_t mk(bit rst, bit sub, int gs, int tg, bit tv, bit nr,
                              int lds, bit cl, int lvl, int sc, int lv,
                              bit go, bit h, bit m);
    vec_t v;
    v.rst = rst; v.sub = sub; v.gs = 10'(gs); v.tg = 10'(tg); v.tv = tv;
    v.nr = nr; v.lds = 4'(lds); v.chk_lds = cl; v.lvl = 2'(lvl);
    v.sc = 16'(sc); v.lv = 2'(lv); v.go = go; v.h = h; v.m = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sub, input int gs, input int tg, input bit tv);
    submit = sub; guess = 10'(gs); target = 10'(tg); target_valid = tv;
  endtask

  // Bounded wait until new_req is visible.
  task automatic wait_req();
    int n = 0;
    while (new_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("new_req_seen", 32'(new_req), 32'd1);
  endtask

  // Enters S_PLAY: target offered in the request cycle must be ignored,
  // then accepted one cycle later. Returns in S_PLAY cycle 1.
  task automatic start_round();
    wait_req();
    drive(0, 0, 37, 1);
    step();
    check("tv_ignored_in_req_cycle", 32'(leds), 32'h0);
    step();
    check("accept_leds", 32'(leds), 32'hF);
    drive(0, 0, 0, 0);
  endtask

  task automatic hit_round(input int exp_lvl, input int exp_sc);
    start_round();
    drive(1, 37, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check("round_hit", 32'(hit), 32'd1);
    check("round_no_miss", 32'(miss), 32'd0);
    check("round_level", 32'(level), 32'(exp_lvl));
    check("round_score", 32'(score), 32'(exp_sc));
  endtask

  vec_t vt[15];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    //         rst sub gs  tg tv | nr lds cl lvl sc lv go h m
    vt[0]  = mk(1, 0,  0,  0, 0,   0, 0,  1, 0, 0, 2, 0, 0, 0);
    vt[1]  = mk(0, 0,  0,  0, 0,   1, 0,  1, 0, 0, 2, 0, 0, 0);
    vt[2]  = mk(0, 0,  0, 99, 1,   0, 0,  1, 0, 0, 2, 0, 0, 0);
    vt[3]  = mk(0, 0,  0, 37, 1,   0, 15, 1, 0, 0, 2, 0, 0, 0);
    vt[4]  = mk(0, 1, 36,  0, 0,   0, 15, 1, 0, 0, 1, 0, 0, 1);
    vt[5]  = mk(0, 0,  0,  0, 0,   0, 15, 1, 0, 0, 1, 0, 0, 0);
    vt[6]  = mk(0, 1, 37,  0, 0,   0, 0,  0, 1, 1, 1, 0, 1, 0);
    vt[7]  = mk(0, 0,  0,  0, 0,   1, 0,  0, 1, 1, 1, 0, 0, 0);
    vt[8]  = mk(0, 1, 37,  0, 0,   0, 0,  0, 1, 1, 1, 0, 0, 0);
    vt[9]  = mk(0, 0,  0, 37, 1,   0, 15, 1, 1, 1, 1, 0, 0, 0);
    vt[10] = mk(0, 1, 36,  0, 0,   0, 0,  1, 1, 1, 0, 1, 0, 1);
    vt[11] = mk(0, 0,  0, 37, 1,   0, 0,  1, 1, 1, 0, 1, 0, 0);
    vt[12] = mk(0, 1,  0,  0, 0,   0, 0,  1, 0, 0, 2, 0, 0, 0);
    vt[13] = mk(0, 0,  0,  0, 0,   1, 0,  1, 0, 0, 2, 0, 0, 0);
    vt[14] = mk(0, 0,  0,  0, 0,   0, 0,  1, 0, 0, 2, 0, 0, 0);

    step();
    for (int i = 0; i < 15; i++) begin
      reset = vt[i].rst;
      drive(vt[i].sub, int'(vt[i].gs), int'(vt[i].tg), vt[i].tv);
      step();
      check($sformatf("v%0d_new_req", i), 32'(new_req), 32'(vt[i].nr));
      if (vt[i].chk_lds) check($sformatf("v%0d_leds", i), 32'(leds), 32'(vt[i].lds));
      check($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].lvl));
      check($sformatf("v%0d_score", i), 32'(score), 32'(vt[i].sc));
      check($sformatf("v%0d_lives", i), 32'(lives_left), 32'(vt[i].lv));
      check($sformatf("v%0d_game_over", i), 32'(game_over), 32'(vt[i].go));
      check($sformatf("v%0d_hit", i), 32'(hit), 32'(vt[i].h));
      check($sformatf("v%0d_miss", i), 32'(miss), 32'(vt[i].m));
    end
    drive(0, 0, 0, 0);

    // Level-0 countdown, 8 cycles per segment, timeout in play cycle 32.
    drive(0, 0, 37, 1);
    step();
    drive(0, 0, 0, 0);
    check("cd_leds_c1", 32'(leds), 32'hF);
    for (int k = 2; k <= 32; k++) begin
      logic [3:0] e;
      step();
      e = (k <= 8) ? 4'hF : (k <= 16) ? 4'h7 : (k <= 24) ? 4'h3 : 4'h1;
      check($sformatf("cd_leds_c%0d", k), 32'(leds), 32'(e));
      if (k == 32) check("cd_no_early_miss", 32'(miss), 32'd0);
    end
    step();
    check("cd_timeout_miss", 32'(miss), 32'd1);
    check("cd_timeout_lives", 32'(lives_left), 32'd1);
    check("cd_timeout_level", 32'(level), 32'd0);
    check("cd_timeout_no_over", 32'(game_over), 32'd0);
    step();
    check("cd_reload_req", 32'(new_req), 32'd1);

    // Five hits: level saturates at 3.
    hit_round(1, 1);
    hit_round(2, 2);
    hit_round(3, 3);
    hit_round(3, 4);
    hit_round(3, 5);

    // Level 3 => one cycle per segment; timeout with last life -> over.
    start_round();
    step(); check("p1_leds_c2", 32'(leds), 32'h7);
    step(); check("p1_leds_c3", 32'(leds), 32'h3);
    step(); check("p1_leds_c4", 32'(leds), 32'h1);
    step();
    check("p1_timeout_miss", 32'(miss), 32'd1);
    check("p1_over", 32'(game_over), 32'd1);
    check("p1_over_lives", 32'(lives_left), 32'd0);
    check("p1_over_leds", 32'(leds), 32'h0);
    check("p1_over_level_held", 32'(level), 32'd3);
    check("p1_over_score_held", 32'(score), 32'd5);
    step();
    check("over_holds", 32'(game_over), 32'd1);
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check("restart_over", 32'(game_over), 32'd0);
    check("restart_score", 32'(score), 32'd0);
    check("restart_level", 32'(level), 32'd0);
    check("restart_lives", 32'(lives_left), 32'd2);
    check("restart_no_req_yet", 32'(new_req), 32'd0);

    // Coincident submit and timeout at level 3.
    hit_round(1, 1);
    hit_round(2, 2);
    hit_round(3, 3);
    start_round();
    step(); step(); step();
    check("co_hit_last_seg", 32'(leds), 32'h1);
    drive(1, 37, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check("co_hit", 32'(hit), 32'd1);
    check("co_hit_no_miss", 32'(miss), 32'd0);
    check("co_hit_lives", 32'(lives_left), 32'd2);
    check("co_hit_score", 32'(score), 32'd4);
    start_round();
    step(); step(); step();
    check("co_miss_last_seg", 32'(leds), 32'h1);
    drive(1, 36, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check("co_miss", 32'(miss), 32'd1);
    check("co_miss_no_hit", 32'(hit), 32'd0);
    check("co_miss_lives", 32'(lives_left), 32'd1);
    check("co_miss_not_over", 32'(game_over), 32'd0);
    step();
    check("co_miss_reload", 32'(new_req), 32'd1);

    // Reset in the middle of a round.
    start_round();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_new_req", 32'(new_req), 32'd0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_lives", 32'(lives_left), 32'd2);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    step();
    start_round();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
